// File: rtl/rr_arbiter_pkt_if.sv
// Arbiter-side bundle for one NoC output port.
// master: input-buffer request logic / downstream side (drives req, tail, out_ready).
// slave:  the arbiter (drives grant, grant_valid, grant_idx, xfer, err_ovlen).
//   req[N]        head flit valid per input buffer
//   tail[N]       current flit of requester i is the tail (valid only while req[i]=1)
//   out_ready     downstream can accept a flit this cycle
//   grant[N]      one-hot grant
//   grant_valid   grant is non-zero
//   grant_idx     binary index of the granted requester
//   xfer          a flit moves this cycle
//   err_ovlen     one-cycle pulse on a forced watchdog release
interface rr_arbiter_pkt_if #(
  parameter int unsigned N = 5
);
  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     tail;
  logic             out_ready;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             xfer;
  logic             err_ovlen;

  modport master (
    output req, tail, out_ready,
    input  grant, grant_valid, grant_idx, xfer, err_ovlen
  );

  modport slave (
    input  req, tail, out_ready,
    output grant, grant_valid, grant_idx, xfer, err_ovlen
  );
endinterface

// File: rtl/rr_arbiter_pkt.sv
// Round-robin output-port arbiter with packet lock (wormhole), downstream ready
// handshake and over-length packet watchdog. One instance per router output port.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   arb_if   slave modport of rr_arbiter_pkt_if (req/tail/out_ready in,
//            grant/grant_valid/grant_idx/xfer/err_ovlen out)
// The last-served requester gets the lowest priority; after every release there is
// one idle (bubble) cycle before the next grant.
module rr_arbiter_pkt #(
  parameter int unsigned N         = 5,
  parameter int unsigned LOCK_EN   = 1,
  parameter int unsigned MAX_FLITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_arbiter_pkt_if.slave      arb_if
);
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(MAX_FLITS + 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             owner_req;
  logic             owner_tail;
  logic             xfer;
  logic             release_own;

  // Circular search starting at ptr+1. Walking from the farthest candidate back to
  // the nearest lets the nearest requester overwrite, so no priority flag is needed.
  always_comb begin
    win_idx  = '0;
    cand_idx = '0;
    for (int k = int'(N); k >= 1; k--) begin
      cand_idx = IDX_W'((int'(ptr_q) + k) % int'(N));
      if (arb_if.req[cand_idx]) begin
        win_idx = cand_idx;
      end
    end
  end

  assign owner_req  = arb_if.req[idx_q];
  assign owner_tail = arb_if.tail[idx_q];
  assign xfer       = (state_q == StBusy) && arb_if.out_ready && owner_req;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    err_d       = 1'b0;
    release_own = 1'b0;
    case (state_q)
      StIdle: begin
        if (|arb_if.req) begin
          state_d = StBusy;
          idx_d   = win_idx;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (!owner_req) begin
          // Owner withdrew its request: release without counting a flit.
          release_own = 1'b1;
        end else if (xfer) begin
          if (cnt_q != CNT_W'(MAX_FLITS)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (LOCK_EN == 0 || owner_tail) begin
            release_own = 1'b1;
          end else if (cnt_q == CNT_W'(MAX_FLITS - 1)) begin
            // Packet reached the flit limit without a tail: force it off the port.
            release_own = 1'b1;
            err_d       = 1'b1;
          end
        end
        // Otherwise stalled on out_ready: hold everything.
        if (release_own) begin
          state_d = StIdle;
          ptr_d   = idx_q;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= IDX_W'(N - 1);
      idx_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  assign arb_if.grant       = grant_q;
  assign arb_if.grant_valid = (state_q == StBusy);
  assign arb_if.grant_idx   = idx_q;
  assign arb_if.xfer        = xfer;
  assign arb_if.err_ovlen   = err_q;

endmodule

// File: tb/tb_rr_arbiter_pkt.sv
// Bench for rr_arbiter_pkt: two instances (packet-lock and per-flit) share one
// stimulus stream; a packet-level reference model predicts each cycle's outputs into
// per-instance queues, and a negedge monitor pops and compares.
module tb_rr_arbiter_pkt;
  localparam int N    = 5;
  localparam int MAXF = 16;

  typedef struct {
    bit busy;
    int owner;
    int ptr;
    int cnt;
    bit err;
  } mst_t;

  typedef struct {
    logic [N-1:0] grant;
    bit           valid;
    int           idx;
    bit           err;
    bit           xfer;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter_pkt_if #(.N(N)) if_lk ();
  rr_arbiter_pkt_if #(.N(N)) if_nl ();

  rr_arbiter_pkt #(.N(N), .LOCK_EN(1), .MAX_FLITS(MAXF)) dut_lk (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (if_lk)
  );

  rr_arbiter_pkt #(.N(N), .LOCK_EN(0), .MAX_FLITS(MAXF)) dut_nl (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (if_nl)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   obs0[$];
  int   obs1[$];
  int   errc0 = 0;
  int   errc1 = 0;
  mst_t st0, st1;

  // ---------------- reference model ----------------
  function automatic mst_t m_reset();
    mst_t s;
    s.busy = 0; s.owner = 0; s.ptr = N - 1; s.cnt = 0; s.err = 0;
    return s;
  endfunction

  function automatic exp_t m_out(mst_t s, logic [N-1:0] rq, logic ordy);
    exp_t         e;
    logic [N-1:0] one;
    one     = 1;
    e.grant = s.busy ? (one << s.owner) : '0;
    e.valid = s.busy;
    e.idx   = s.owner;
    e.err   = s.err;
    e.xfer  = s.busy && ordy && rq[s.owner];
    return e;
  endfunction

  function automatic mst_t m_step(mst_t s, logic [N-1:0] rq, logic [N-1:0] tl,
                                  logic ordy, bit lock);
    mst_t n;
    bit   found;
    bit   rel;
    n     = s;
    n.err = 0;
    rel   = 0;
    if (!s.busy) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && rq[(s.ptr + k) % N]) begin
          found   = 1;
          n.owner = (s.ptr + k) % N;
        end
      end
      n.busy = found;
      if (found) n.cnt = 0;
    end else if (!rq[s.owner]) begin
      rel = 1;
    end else if (ordy) begin
      n.cnt = (s.cnt < MAXF) ? s.cnt + 1 : s.cnt;
      if (!lock || tl[s.owner]) rel = 1;
      else if (s.cnt + 1 == MAXF) begin
        rel   = 1;
        n.err = 1;
      end
    end
    if (rel) begin
      n.busy = 0;
      n.ptr  = s.owner;
    end
    return n;
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] tl,
                     input logic ordy);
    @(posedge clk);
    #1;
    rst_n           = r;
    if_lk.req       = rq;
    if_lk.tail      = tl;
    if_lk.out_ready = ordy;
    if_nl.req       = rq;
    if_nl.tail      = tl;
    if_nl.out_ready = ordy;
    if (!r) begin
      st0 = m_reset();
      st1 = m_reset();
    end
    q0.push_back(m_out(st0, rq, ordy));
    q1.push_back(m_out(st1, rq, ordy));
    if (r) begin
      st0 = m_step(st0, rq, tl, ordy, 1'b1);
      st1 = m_step(st1, rq, tl, ordy, 1'b0);
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    obs0.delete();
    obs1.delete();
    errc0 = 0;
    errc1 = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_seq(input string nm, input int d, input int ex[$]);
    int got[$];
    if (d == 0) got = obs0;
    else got = obs1;
    for (int i = 0; i < ex.size(); i++) begin
      n_checks++;
      if (i >= got.size()) begin
        n_fail++;
        $display("FAIL %s grant #%0d: got none, required index %0d", nm, i, ex[i]);
      end else if (got[i] != ex[i]) begin
        n_fail++;
        $display("FAIL %s grant #%0d: got index %0d, required %0d", nm, i, got[i], ex[i]);
      end
    end
  endtask

  task automatic check_val(input string nm, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic cmp(input string nm, input exp_t e, input logic [N-1:0] g, input logic v,
                     input int idx, input logic er, input logic x);
    bit ok;
    n_checks++;
    ok = (g === e.grant) && (v === e.valid) && (er === e.err) && (x === e.xfer) &&
         (!e.valid || idx == e.idx);
    if (!ok) begin
      n_fail++;
      $display("FAIL %s t=%0t: got grant=%b valid=%b idx=%0d err=%b xfer=%b, required grant=%b valid=%b idx=%0d err=%b xfer=%b",
               nm, $time, g, v, idx, er, x, e.grant, e.valid, e.idx, e.err, e.xfer);
    end
  endtask

  initial begin
    logic prev0, prev1;
    exp_t e;
    prev0 = 1'b0;
    prev1 = 1'b0;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("lock", e, if_lk.grant, if_lk.grant_valid, int'(if_lk.grant_idx),
            if_lk.err_ovlen, if_lk.xfer);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("nolock", e, if_nl.grant, if_nl.grant_valid, int'(if_nl.grant_idx),
            if_nl.err_ovlen, if_nl.xfer);
      end
      if (if_lk.grant_valid === 1'b1 && !prev0) obs0.push_back(int'(if_lk.grant_idx));
      if (if_nl.grant_valid === 1'b1 && !prev1) obs1.push_back(int'(if_nl.grant_idx));
      if (if_lk.err_ovlen === 1'b1) errc0++;
      if (if_nl.err_ovlen === 1'b1) errc1++;
      prev0 = (if_lk.grant_valid === 1'b1);
      prev1 = (if_nl.grant_valid === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int           ex[$];
    logic [N-1:0] rq;
    logic [N-1:0] tl;
    logic         r;
    logic         ordy;
    st0 = m_reset();
    st1 = m_reset();
    if_lk.req = '0; if_lk.tail = '0; if_lk.out_ready = 1'b0;
    if_nl.req = '0; if_nl.tail = '0; if_nl.out_ready = 1'b0;

    // 1: everyone requesting single-flit packets.
    do_reset();
    for (int i = 0; i < 14; i++) cyc(1'b1, 5'b11111, 5'b11111, 1'b1);
    settle();
    ex = '{0, 1, 2, 3, 4, 0};
    check_seq("t1_rr_order", 0, ex);

    // 2: owner 1 stalled by out_ready while 2 waits.
    do_reset();
    cyc(1'b1, 5'b00010, 5'b00010, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'b00110, 5'b00010, 1'b0);
    cyc(1'b1, 5'b00110, 5'b00010, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'b00100, 5'b00100, 1'b0);
    settle();
    ex = '{1, 2};
    check_seq("t2_stall", 0, ex);

    // 3: 4-flit packet from 3 with 0 waiting.
    do_reset();
    cyc(1'b1, 5'b01000, 5'b00000, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 5'b01001, (i == 4) ? 5'b01000 : 5'b00000, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'b00001, 5'b00000, 1'b1);
    settle();
    ex = '{3, 0};
    check_seq("t3_lock", 0, ex);

    // 4: requester 4 streams 20 flits without a tail.
    do_reset();
    cyc(1'b1, 5'b10000, 5'b00000, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 5'b10001, 5'b00000, 1'b1);
    settle();
    ex = '{4, 0};
    check_seq("t4_watchdog", 0, ex);
    check_val("t4_err_pulses", errc0, 1);

    // 5: per-flit arbitration between 1 and 2.
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1'b1, 5'b00110, 5'b00000, 1'b1);
    settle();
    ex = '{1, 2, 1, 2};
    check_seq("t5_nolock_alt", 1, ex);
    check_val("t5_err_pulses", errc1, 0);

    // 6: reset in the middle of a packet from 2.
    do_reset();
    cyc(1'b1, 5'b00100, 5'b00000, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 5'b00100, 5'b00000, 1'b1);
    obs0.delete();
    cyc(1'b0, 5'b00101, 5'b00000, 1'b1);
    cyc(1'b0, 5'b00101, 5'b00000, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'b00101, 5'b00000, 1'b0);
    settle();
    ex = '{0};
    check_seq("t6_reset_mid", 0, ex);

    // Random traffic with sticky requests, sparse tails and occasional reset.
    rq = '0;
    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(0, 149) != 0);
      rq   = rq ^ N'($urandom & $urandom & $urandom);
      tl   = N'($urandom & $urandom & $urandom);
      ordy = ($urandom_range(0, 3) != 0);
      cyc(r, rq, tl, ordy);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, '0, 1'b1);
    settle();
    check_val("scoreboard_drained_lock", q0.size(), 0);
    check_val("scoreboard_drained_nolock", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
